// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates the I-fetch and D load/store ports onto one fixed-latency memory
// Define ROUND_ROBIN_EN to alternate grants on contention; otherwise D always beats I.
module mem_arbiter #(
  parameter int MEM_LATENCY = 20,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] LAST_COUNT = 8'(MEM_LATENCY - 1);

  state_t            state;
  logic [7:0]        count;
  logic              grant_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pick_d;

`ifdef ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_stall   = i_req & ~i_ready;
  assign d_stall   = d_req & ~d_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 8'd0;
      grant_d <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            grant_d <= pick_d;
            addr_q  <= pick_d ? d_addr : i_addr;
            wdata_q <= pick_d ? d_wdata : '0;
            we_q    <= pick_d & d_we;
            count   <= LAST_COUNT;
            mem_en  <= 1'b1;
            // With a single BUSY cycle the strobe must already be up on entry.
            mem_we  <= (LAST_COUNT == 8'd0) & pick_d & d_we;
            state   <= BUSY;
`ifdef ROUND_ROBIN_EN
            last_d  <= pick_d;
`endif
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (grant_d) begin
              d_ready <= 1'b1;
              if (!we_q) d_rdata <= mem_rdata;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= mem_rdata;
            end
            state <= DONE;
          end else begin
            count  <= count - 8'd1;
            mem_we <= (count == 8'd1) & we_q;
          end
        end
        DONE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed table, corner sequences, random vs model)
module tb_mem_arbiter;

  localparam int L = 20;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ready, i_stall, d_ready, d_stall, mem_en, mem_we;

  logic        i_req1;
  logic [31:0] i_addr1, mem_rdata1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        i_ready1, i_stall1, d_ready1, d_stall1, mem_en1, mem_we1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) u0 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1), .i_stall(i_stall1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_rdata(d_rdata1),
    .d_ready(d_ready1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] tmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  int          n_chk = 0;
  int          n_fail = 0;

  int          edges, nwe, nen, we_edge, de, ie, nev, np, n, m_g, m_idle, dd;
  bit          got, stall_ok, exp_r, m_act, m_pd, m_we, m_last_d, x_en, x_we, x_ir, x_dr;
  logic [31:0] we_addr, m_addr, m_wdata, e_i, e_d;
  bit          ev_d [3];
  int          ev_e [3];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return tmem.exists(a) ? tmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 7) * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: memory model writes on the strobe and presents read data for the next edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mem_we) tmem[mem_addr] = mem_wdata;
    mem_rdata  = rd(mem_addr);
    mem_rdata1 = mem_addr1 ^ 32'hC0DE_0000;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h4,  32'hEEEE_EEEE, 32'h0,         32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h4,  32'h0,         32'h0,         32'hEEEE_EEEE};
    vt[2] = '{1'b0, 1'b0, 32'h4,  32'h0,         32'hEEEE_EEEE, 32'hEEEE_EEEE};
    vt[3] = '{1'b1, 1'b1, 32'h10, 32'h1234_5678, 32'hEEEE_EEEE, 32'hEEEE_EEEE};
    vt[4] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hEEEE_EEEE, 32'h1234_5678};
    vt[5] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h5A5A_0020, 32'h1234_5678};

    reset_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0; i_addr1 = 0; mem_rdata = 0; mem_rdata1 = 0;
    tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("idle_mem_en", mem_en, 0);
      check("idle_stalls", {i_stall, d_stall, i_ready, d_ready}, 4'b0);
      check("idle_rdata", {i_rdata, d_rdata}, 64'h0);
    end

    // Directed single-port accesses from the table
    for (int r = 0; r < 6; r++) begin
      edges = 0; nwe = 0; nen = 0; we_edge = -1; we_addr = 0; got = 0; stall_ok = 1;
      if (vt[r].port_d) begin
        d_req = 1; d_we = vt[r].we; d_addr = vt[r].addr; d_wdata = vt[r].wdata;
      end else begin
        i_req = 1; i_addr = vt[r].addr;
      end
      while (!got && edges < 100) begin
        tick();
        edges++;
        if (mem_en) nen++;
        if (mem_we) begin nwe++; we_edge = edges; we_addr = mem_addr; end
        got = vt[r].port_d ? d_ready : i_ready;
        if (got == (vt[r].port_d ? d_stall : i_stall)) stall_ok = 0;
      end
      check("vec_latency", edges, L + 1);
      check("vec_en_cycles", nen, L);
      check("vec_we_count", nwe, 64'(vt[r].we));
      if (vt[r].we) begin
        check("vec_we_edge", we_edge, L);
        check("vec_we_addr", we_addr, vt[r].addr);
      end
      check("vec_stall", stall_ok, 1);
      check("vec_i_rdata", i_rdata, vt[r].exp_i);
      check("vec_d_rdata", d_rdata, vt[r].exp_d);
      i_req = 0; d_req = 0;
      tick();
      check("vec_ready_low", {i_ready, d_ready}, 2'b00);
      check("vec_rdata_held", {i_rdata, d_rdata}, {vt[r].exp_i, vt[r].exp_d});
    end

    // Contention: D first, I after one IDLE cycle
    i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h400C;
    de = -1; ie = -1;
    for (int e = 1; e <= 100 && (de < 0 || ie < 0); e++) begin
      tick();
      if (e == 1) check("pair1_first_addr", mem_addr, 32'h400C);
      if (d_ready) begin
        de = e; d_req = 0;
        check("pair1_i_stall_held", i_stall, 1);
        check("pair1_d_rdata", d_rdata, 32'h5A5A_400C);
      end
      if (i_ready) begin
        ie = e; i_req = 0;
        check("pair1_i_rdata", i_rdata, 32'h5A5A_0000);
      end
    end
    check("pair1_d_edge", de, L + 1);
    check("pair1_i_edge", ie, 2 * L + 3);
    tick();

    // Contention with D re-requesting back-to-back
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h4010;
    nev = 0;
    for (int e = 1; e <= 200 && nev < 3; e++) begin
      tick();
      if (d_ready || i_ready) begin
        ev_d[nev] = d_ready; ev_e[nev] = e; nev++;
        if (nev >= 2) begin
          if (d_ready) d_req = 0; else i_req = 0;
        end
      end
    end
    tick();
    check("pair2_events", nev, 3);
    check("pair2_first", {ev_d[0], 32'(ev_e[0])}, {1'b1, 32'(L + 1)});
    check("pair2_second", {ev_d[1], 32'(ev_e[1])}, {!RR, 32'(2 * L + 3)});
    check("pair2_third", {ev_d[2], 32'(ev_e[2])}, {RR, 32'(3 * L + 5)});

    // Asynchronous reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 32'h800C; d_wdata = 32'hABCD_0123;
    repeat (10) tick();
    check("abort_en_before", mem_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_en_now", mem_en, 0);
    check("abort_we_now", mem_we, 0);
    check("abort_ready", d_ready, 0);
    check("abort_rdata", {i_rdata, d_rdata}, 64'h0);
    tick();
    check("abort_no_write", tmem.exists(32'h800C), 0);
    reset_n = 1'b1;
    edges = 0; nwe = 0; got = 0;
    while (!got && edges < 100) begin
      tick();
      edges++;
      if (mem_we) nwe++;
      got = d_ready;
    end
    check("reissue_latency", edges, L + 1);
    check("reissue_we_count", nwe, 1);
    check("reissue_mem", rd(32'h800C), 32'hABCD_0123);
    check("reissue_d_rdata", d_rdata, 32'h0);
    d_req = 0;
    tick();

    // MEM_LATENCY=1, fetch held high
    i_req1 = 1; i_addr1 = 32'h40;
    np = 0; nen = 0; nwe = 0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      exp_r = (e >= 2) && ((e - 2) % 3 == 0);
      check("lat1_ready", i_ready1, exp_r);
      check("lat1_stall", i_stall1, !exp_r);
      if (i_ready1) begin
        np++;
        check("lat1_rdata", i_rdata1, 32'hC0DE_0040);
      end
      if (mem_en1) nen++;
      if (mem_we1 || d_ready1 || d_stall1) nwe++;
    end
    check("lat1_pulses", np, 5);
    check("lat1_en_cycles", nen, 5);
    check("lat1_d_side_quiet", nwe, 0);
    check("lat1_d_rdata", d_rdata1, 0);
    check("lat1_wdata", mem_wdata1, 0);
    i_req1 = 0;
    tick();

    // Random traffic against a transaction-level model
    reset_n = 1'b0;
    i_req = 0; d_req = 0;
    tick();
    reset_n = 1'b1;
    mmem = tmem;
    m_act = 0; m_idle = 0; m_g = 0; m_last_d = 0; m_pd = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; e_i = 0; e_d = 0;
    for (n = 0; n < 3000; n++) begin
      tick();
      if (m_act && (n - m_g) > L) m_act = 0;
      if (!m_act && n >= m_idle && (i_req || d_req)) begin
        if (i_req && d_req) m_pd = RR ? !m_last_d : 1'b1;
        else m_pd = d_req;
        m_last_d = m_pd;
        m_act = 1; m_g = n; m_idle = n + L + 2;
        m_we = m_pd && d_we;
        m_addr = m_pd ? d_addr : i_addr;
        m_wdata = d_wdata;
      end
      dd = n - m_g;
      x_en = m_act && dd < L;
      x_we = m_act && dd == L - 1 && m_we;
      x_ir = m_act && dd == L && !m_pd;
      x_dr = m_act && dd == L && m_pd;
      if (x_ir) e_i = mrd(m_addr);
      if (x_dr) begin
        if (m_we) mmem[m_addr] = m_wdata;
        else e_d = mrd(m_addr);
      end
      check("rnd_mem_en", mem_en, x_en);
      check("rnd_mem_we", mem_we, x_we);
      if (x_en) check("rnd_mem_addr", mem_addr, m_addr);
      if (x_we) check("rnd_mem_wdata", mem_wdata, m_wdata);
      check("rnd_ready", {i_ready, d_ready}, {x_ir, x_dr});
      check("rnd_stall", {i_stall, d_stall}, {i_req && !x_ir, d_req && !x_dr});
      check("rnd_rdata", {i_rdata, d_rdata}, {e_i, e_d});
      if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = raddr(); end
      end else if (x_ir) begin
        if ($urandom_range(0, 1) == 1) i_req = 0; else i_addr = raddr();
      end else if ($urandom_range(0, 3) == 0) i_addr = raddr();
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = raddr(); d_wdata = $urandom;
        end
      end else if (x_dr) begin
        if ($urandom_range(0, 1) == 1) d_req = 0;
        else begin d_we = 1'($urandom_range(0, 1)); d_addr = raddr(); d_wdata = $urandom; end
      end else if ($urandom_range(0, 3) == 0) begin
        d_we = 1'($urandom_range(0, 1)); d_addr = raddr(); d_wdata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
